// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: controller states,
// default word width and an address-width helper.
// Optional feature macro used by regfile_mp: REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int WORD = 32;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Smallest r with 2**r >= value (at least 1 so a 2-entry file gets one bit).
  function automatic int regfile_clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every entry once writing zero, then
// raises ready and stays in RUN until the next reset.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int ABITS = regfile_clog2(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             clear_we,
  output logic [ABITS-1:0] clear_addr,
  output logic             ready
);

  localparam logic [ABITS-1:0] LAST_IDX = ABITS'(SIZE - 1);

  state_e           state_q, state_d;
  logic [ABITS-1:0] idx_q, idx_d;
  logic             ready_q, ready_d;

  // Next-state: advance the clear index, leave CLEAR after the last entry.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    case (state_q)
      ST_CLEAR: begin
        idx_d = idx_q + ABITS'(1);
        if (idx_q == LAST_IDX) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
          idx_d   = '0;
        end
      end
      default: ready_d = 1'b1;
    endcase
  end

  // State registers; reset restarts the clear from entry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  assign clear_we   = (state_q == ST_CLEAR);
  assign clear_addr = idx_q;
  assign ready      = ready_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, NUM_READ registered
// read ports, hardwired zero at address 0 and a hardware clear after reset.
// Define REGFILE_BYPASS_EN to forward same-edge write data to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = WORD,
  parameter int SIZE     = 32,
  parameter int NUM_READ = 2,
  parameter int ABITS    = regfile_clog2(SIZE)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                we,
  input  logic [2*ABITS-1:0]        waddr,
  input  logic [2*WIDTH-1:0]        wdata,
  input  logic [NUM_READ*ABITS-1:0] raddr,
  output logic [NUM_READ*WIDTH-1:0] rdata,
  output logic                      ready
);

  logic             clear_we;
  logic [ABITS-1:0] clear_addr;

  regfile_clear_seq #(
    .SIZE  (SIZE),
    .ABITS (ABITS)
  ) u_clear_seq (
    .clk        (clk),
    .reset      (reset),
    .clear_we   (clear_we),
    .clear_addr (clear_addr),
    .ready      (ready)
  );

  logic [WIDTH-1:0] mem_q [SIZE];

  logic [1:0]       wr_en;
  logic [ABITS-1:0] wr_addr [2];
  logic [WIDTH-1:0] wr_data [2];
  logic [1:0]       user_en;

  genvar gi;

  // User write qualification: only in RUN, never to address 0, not under reset.
  for (gi = 0; gi < 2; gi++) begin : g_wq
    assign user_en[gi] = we[gi] && ready && !reset && (waddr[gi*ABITS +: ABITS] != '0);
  end

  // Port 0 carries the clear stream while not ready; port 1 wins same-address conflicts.
  always_comb begin
    wr_addr[1] = waddr[ABITS +: ABITS];
    wr_data[1] = wdata[WIDTH +: WIDTH];
    wr_en[1]   = user_en[1];
    if (!ready) begin
      wr_addr[0] = clear_addr;
      wr_data[0] = '0;
      wr_en[0]   = clear_we && !reset;
    end else begin
      wr_addr[0] = waddr[0 +: ABITS];
      wr_data[0] = wdata[0 +: WIDTH];
      wr_en[0]   = user_en[0] && !(user_en[1] && (wr_addr[1] == waddr[0 +: ABITS]));
    end
  end

  // Storage array update from both write ports.
  always_ff @(posedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (wr_en[w]) mem_q[wr_addr[w]] <= wr_data[w];
    end
  end

  for (gi = 0; gi < NUM_READ; gi++) begin : g_rd
    logic [ABITS-1:0] ra;
    logic [WIDTH-1:0] rd_d, rd_q;

    assign ra = raddr[gi*ABITS +: ABITS];

    // Read select: array, optional forwarding (port 1 first), zero for addr 0 / CLEAR.
    always_comb begin
      rd_d = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
      if (user_en[1] && (wr_addr[1] == ra)) begin
        rd_d = wr_data[1];
      end else if (user_en[0] && (waddr[0 +: ABITS] == ra)) begin
        rd_d = wdata[0 +: WIDTH];
      end
`else
`endif
      if ((ra == '0) || !ready) rd_d = '0;
    end

    // Registered read output.
    always_ff @(posedge clk) begin
      if (reset) rd_q <= '0;
      else       rd_q <= rd_d;
    end

    assign rdata[gi*WIDTH +: WIDTH] = rd_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: the driver pushes expected read data when
// it issues a read; a monitor pops and compares after the read edge.
`timescale 1ns/1ps
module tb_regfile_mp;

  localparam int WIDTH    = 32;
  localparam int SIZE     = 32;
  localparam int NUM_READ = 2;
  localparam int ABITS    = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      reset;
  logic [1:0]                we;
  logic [2*ABITS-1:0]        waddr;
  logic [2*WIDTH-1:0]        wdata;
  logic [NUM_READ*ABITS-1:0] raddr;
  logic [NUM_READ*WIDTH-1:0] rdata;
  logic                      ready;

  always #5 clk = ~clk;

  regfile_mp #(
    .WIDTH    (WIDTH),
    .SIZE     (SIZE),
    .NUM_READ (NUM_READ)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata),
    .ready (ready)
  );

  typedef struct {
    string            name;
    logic [WIDTH-1:0] e0;
    logic [WIDTH-1:0] e1;
  } exp_t;

  exp_t sbq[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  logic rd_valid = 1'b0;
  logic pend_q   = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle: drive write/read ports, optionally register an expected read.
  task automatic cyc(input logic [1:0] w,
                     input logic [ABITS-1:0] wa0, input logic [WIDTH-1:0] wd0,
                     input logic [ABITS-1:0] wa1, input logic [WIDTH-1:0] wd1,
                     input logic rv,
                     input logic [ABITS-1:0] ra0, input logic [ABITS-1:0] ra1,
                     input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                     input string nm);
    exp_t e;
    we       = w;
    waddr    = {wa1, wa0};
    wdata    = {wd1, wd0};
    raddr    = {ra1, ra0};
    rd_valid = rv;
    if (rv) begin
      e.name = nm; e.e0 = e0; e.e1 = e1;
      sbq.push_back(e);
    end
    tick();
    we       = 2'b00;
    rd_valid = 1'b0;
  endtask

  // A read issued at edge N is compared on the falling edge after N.
  always @(posedge clk) pend_q <= rd_valid && !reset;

  always @(negedge clk) begin
    exp_t e;
    if (pend_q) begin
      if (sbq.size() == 0) begin
        chk_cnt++;
        $display("FAIL sb_underflow: got read with no expectation");
      end else begin
        e = sbq.pop_front();
        $display("rd %s p0=%h p1=%h", e.name, rdata[0 +: WIDTH], rdata[WIDTH +: WIDTH]);
        check({e.name, "_p0"}, 64'(rdata[0 +: WIDTH]), 64'(e.e0));
        check({e.name, "_p1"}, 64'(rdata[WIDTH +: WIDTH]), 64'(e.e1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; we = '0; waddr = '0; wdata = '0; raddr = '0;
    repeat (3) tick();
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_rdata", rdata, 64'd0);

    // Release reset: ready must rise exactly after the SIZE-th edge.
    reset = 1'b0;
    raddr = {5'd4, 5'd3};
    for (int k = 1; k <= SIZE; k++) begin
      tick();
      check("clr_ready", 64'(ready), 64'(k == SIZE));
      check("clr_rdata", rdata, 64'd0);
    end

    // Every register reads zero after the clear.
    for (int a = 0; a < SIZE; a += 2)
      cyc(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, ABITS'(a), ABITS'(a + 1), 32'h0, 32'h0, "zero");

    cyc(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, "wr5");
    cyc(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, "rd5");

    cyc(2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222, 1'b1, 5'd7, 5'd7,
        BYP ? 32'h22222222 : 32'h0, BYP ? 32'h22222222 : 32'h0, "wr7_same");
    cyc(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 32'h22222222, 32'h22222222, "rd7");

    cyc(2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 32'h0, 32'h0, "wr0_same");
    cyc(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 32'h0, 32'h0, "rd0");

    cyc(2'b10, 5'd0, 32'h0, 5'd9, 32'h00000001, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, "wr9_old");
    cyc(2'b01, 5'd9, 32'hA5A5A5A5, 5'd0, 32'h0, 1'b1, 5'd9, 5'd5,
        BYP ? 32'hA5A5A5A5 : 32'h00000001, 32'hDEADBEEF, "wr9_same");
    cyc(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd7, 32'hA5A5A5A5, 32'h22222222, "rd9");

    cyc(2'b11, 5'd12, 32'h0000C0C0, 5'd13, 32'h0000D0D0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, "wr12_13");
    cyc(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd13, 32'h0000C0C0, 32'h0000D0D0, "rd12_13");
    tick();

    // Reset again, interrupt the clear at index 10 with a write in the reset cycle.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    we = 2'b01; waddr = {5'd0, 5'd14}; wdata = {32'h0, 32'h00000BAD};
    tick();
    reset = 1'b0;
    we = 2'b00;
    for (int k = 1; k <= SIZE; k++) begin
      if (k == 21) begin
        we = 2'b11; waddr = {5'd4, 5'd3}; wdata = {32'h44444444, 32'h33333333};
      end
      tick();
      we = 2'b00;
      check("reclr_ready", 64'(ready), 64'(k == SIZE));
    end

    cyc(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd4, 32'h0, 32'h0, "lost_clr");
    cyc(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd14, 5'd7, 32'h0, 32'h0, "lost_rst");
    cyc(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd12, 32'h0, 32'h0, "recleared");
    cyc(2'b01, 5'd3, 32'h00000033, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, "wr3");
    cyc(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd5, 32'h00000033, 32'h0, "rd3");
    repeat (2) tick();

    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, the next-generation replacement for the decode-stage register file. It adds configurable width, depth and read-port count, and two write ports with fixed priority. It also adds a hardwired zero register, single-edge (posedge) timing with optional write-to-read forwarding, and a hardware clear sequencer that zeroes the array after reset. It sits in the decode stage, feeding operand registers and taking writeback from up to two retiring instructions per cycle.

## Interface
Parameters:
- WIDTH, 32, data word width in bits
- SIZE, 32, number of registers; power of two, ≥ 2
- NUM_READ, 2, number of read ports, 1–4
- ABITS, clog2(SIZE), address width (derived; not overridden)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- we  input  2  write enables, bit w for write port w
- waddr  input  2*ABITS  packed write addresses, port w at [w*ABITS +: ABITS]
- wdata  input  2*WIDTH  packed write data, port w at [w*WIDTH +: WIDTH]
- raddr  input  NUM_READ*ABITS  packed read addresses
- rdata  output  NUM_READ*WIDTH  packed registered read data
- ready  output  1  high when the array is initialised and accepting writes

## Operation
- Two-state FSM: CLEAR, RUN. Reset forces CLEAR, clear index 0, ready=0, rdata=0.
- CLEAR:
  - Each cycle, writes 0 to entry[idx] and increments idx.
  - At idx==SIZE-1, the FSM moves to RUN on the following edge.
  - we is ignored; rdata holds 0.
- RUN: ready=1.
  - Each enabled write port updates its entry at the clock edge.
  - Every read port registers entry[raddr] each cycle, with no read enable.
- Write conflict: both ports enabled to the same address → port 1 wins; port 0's write is dropped.
- Address 0 is hardwired to zero: writes are discarded and reads always return 0, including when forwarding.
- Reset asserted mid-CLEAR or mid-RUN:
  - Returns to CLEAR with idx=0 on the next edge.
  - Any write presented in the same cycle is dropped.
- Out-of-range addresses cannot occur, because SIZE is a power of two.

## Timing
- Read latency is 1 cycle: raddr sampled at edge N, rdata valid after edge N, stable until edge N+1.
- Write takes effect at edge N; a read of the same address at edge N+1 returns the new value.
- Same-edge read/write collision depends on REGFILE_BYPASS_EN (see Configuration).
- The clear phase lasts exactly SIZE cycles after the first edge with reset low. ready rises after edge SIZE; for SIZE=32, on the 32nd edge after reset deasserts.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read at edge N whose address matches an enabled, non-zero write address at edge N returns that write's data.
  - If both write ports match, port 1's data is returned.
- REGFILE_BYPASS_EN undefined: a read at edge N returns the pre-write (old) value. The new value is visible from edge N+1.
- Either setting: address 0 always reads 0, and no forwarding occurs during CLEAR.

## Structure
- Shared package regfile_pkg:
  - State enum (CLEAR, RUN).
  - WORD default width constant.
  - Clog2 helper function.
- Sub-module regfile_clear_seq:
  - Contains the FSM and the ABITS-wide clear index.
  - Outputs clear_we, clear_addr and ready.
  - The top level muxes clear_we/clear_addr over port 0 during CLEAR.
- Top level holds the storage array, the write-priority logic, the read registers and the bypass compare.

## Test plan
- Reset, then release:
  - ready=0 and rdata=0 for 32 cycles, ready=1 after the 32nd edge.
  - Every register then reads 0x00000000.
- RUN, write port 0 addr 5 = 0xDEADBEEF, then read addr 5 on the next cycle → rdata[0]=0xDEADBEEF one cycle later.
- Same cycle, port 0 and port 1 both write addr 7, 0x11111111 and 0x22222222 → subsequent read of addr 7 = 0x22222222.
- Write addr 0 = 0xFFFFFFFF on both ports → read addr 0 = 0 on every read port, with the macro both defined and undefined.
- Same-edge write addr 9 = 0xA5A5A5A5 and read addr 9, with old value 0x1:
  - Defined → rdata=0xA5A5A5A5.
  - Undefined → rdata=0x00000001, then 0xA5A5A5A5 on the next read.
- Reset pulsed at clear index 10:
  - The clear restarts from 0, and ready rises exactly SIZE cycles after this reset deasserts.
  - A write presented during CLEAR is lost, so its register reads 0 in RUN.
